dac_sample_scheduler: RTL and testbench

- Sequences the SPI DAC output controller at a fixed audio sample rate.
- Arbitrates between three sample sources (music keys, song player, recording player), choosing one by the current music-box state.
- Drives the controller's sample and active-low send inputs, and tracks the busy/complete handshake.
- Sits between the sample-producing blocks and the SPI DAC controller in the top level.

---
 rtl/dac_sample_scheduler.sv | 229 ++++++++++++++++++++++
 tb/tb_dac_sample_scheduler.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_sample_scheduler.sv
// Paces SPI DAC sample transfers at a fixed sample rate and arbitrates keys/song/recording sources.
// Optional macro SAMPLE_MIX_EN: in state 3 mixes key and recording samples when both are valid.
module dac_sample_scheduler #(
    parameter int unsigned SAMPLE_DIVIDER = 1136,
    parameter int unsigned SEND_TIMEOUT   = 16,
    parameter int unsigned SILENCE_CODE   = 2048
) (
    input  logic        clock_50Mhz,
    input  logic        reset_n,
    input  logic [4:0]  currentState,
    input  logic [11:0] keys_sample,
    input  logic        keys_valid,
    output logic        keys_ack,
    input  logic [11:0] song_sample,
    input  logic        song_valid,
    output logic        song_ack,
    input  logic [11:0] rec_sample,
    input  logic        rec_valid,
    output logic        rec_ack,
    output logic [11:0] dac_inputSample,
    output logic        dac_sendSample_n,
    input  logic        dac_isBusy,
    input  logic        dac_transmitComplete,
    output logic [7:0]  overrunCount,
    output logic [1:0]  activeSource
);

    localparam int unsigned SAMPLE_W = 12;
    localparam int unsigned CNT_W    = (SAMPLE_DIVIDER > 1) ? $clog2(SAMPLE_DIVIDER) : 1;
    localparam int unsigned TO_W     = $clog2(SEND_TIMEOUT + 1);

    localparam logic [SAMPLE_W-1:0] SILENCE = SAMPLE_W'(SILENCE_CODE);
    localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(SAMPLE_DIVIDER - 1);
    localparam logic [TO_W-1:0]     TO_MAX  = TO_W'(SEND_TIMEOUT - 1);

    localparam logic [1:0] SRC_NONE = 2'd0;
    localparam logic [1:0] SRC_KEYS = 2'd1;
    localparam logic [1:0] SRC_SONG = 2'd2;
    localparam logic [1:0] SRC_REC  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LATCH = 2'd1,
        S_SEND  = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t              state, state_d;
    logic [CNT_W-1:0]    tick_cnt;
    logic                tick;
    logic [TO_W-1:0]     to_cnt, to_cnt_d;
    logic [1:0]          sel;

    logic [SAMPLE_W-1:0] pick_sample;
    logic [1:0]          pick_src;
    logic                pick_keys, pick_song, pick_rec;

    logic [SAMPLE_W-1:0] sample_d;
    logic [1:0]          src_d;
    logic                keys_ack_d, song_ack_d, rec_ack_d;
    logic                send_n_d;
    logic                overrun_inc;
    logic [7:0]          overrun_d;

    // Free-running sample-rate divider
    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
        end
    end

    assign tick = (tick_cnt == CNT_MAX);

    // Source selection by music-box state
    always_comb begin
        sel = SRC_NONE;
        case (currentState)
            5'd1, 5'd3: sel = SRC_KEYS;
            5'd2:       sel = SRC_SONG;
            5'd4:       sel = SRC_REC;
            default:    sel = SRC_NONE;
        endcase
    end

`ifdef SAMPLE_MIX_EN
    localparam int unsigned MIX_W    = SAMPLE_W + 2;
    localparam int unsigned MIDSCALE = 2048;

    logic                    mix_both;
    logic signed [MIX_W-1:0] mix_sum;
    logic [SAMPLE_W-1:0]     mix_sample;

    assign mix_both = (currentState == 5'd3) && keys_valid && rec_valid;
    assign mix_sum  = $signed(MIX_W'(keys_sample)) + $signed(MIX_W'(rec_sample))
                    - $signed(MIX_W'(MIDSCALE));

    // Clamp the offset-binary sum into the 12-bit code range
    always_comb begin
        if (mix_sum[MIX_W-1]) begin
            mix_sample = '0;
        end else if (mix_sum[MIX_W-2:SAMPLE_W] != '0) begin
            mix_sample = '1;
        end else begin
            mix_sample = mix_sum[SAMPLE_W-1:0];
        end
    end
`endif

    // Sample/ack choice captured when a tick is accepted
    always_comb begin
        pick_sample = SILENCE;
        pick_src    = SRC_NONE;
        pick_keys   = 1'b0;
        pick_song   = 1'b0;
        pick_rec    = 1'b0;
        case (sel)
            SRC_KEYS: if (keys_valid) begin
                pick_sample = keys_sample;
                pick_src    = SRC_KEYS;
                pick_keys   = 1'b1;
            end
            SRC_SONG: if (song_valid) begin
                pick_sample = song_sample;
                pick_src    = SRC_SONG;
                pick_song   = 1'b1;
            end
            SRC_REC: if (rec_valid) begin
                pick_sample = rec_sample;
                pick_src    = SRC_REC;
                pick_rec    = 1'b1;
            end
            default: ;
        endcase
`ifdef SAMPLE_MIX_EN
        if (mix_both) begin
            pick_sample = mix_sample;
            pick_src    = SRC_KEYS;
            pick_keys   = 1'b1;
            pick_rec    = 1'b1;
        end
`endif
    end

    // Transfer sequencing; sample and ack are registered so they are visible during LATCH
    always_comb begin
        state_d     = state;
        to_cnt_d    = to_cnt;
        sample_d    = dac_inputSample;
        src_d       = activeSource;
        keys_ack_d  = 1'b0;
        song_ack_d  = 1'b0;
        rec_ack_d   = 1'b0;
        send_n_d    = 1'b1;
        overrun_inc = 1'b0;

        case (state)
            S_IDLE: begin
                if (tick) begin
                    state_d    = S_LATCH;
                    sample_d   = pick_sample;
                    src_d      = pick_src;
                    keys_ack_d = pick_keys;
                    song_ack_d = pick_song;
                    rec_ack_d  = pick_rec;
                end
            end
            S_LATCH: begin
                overrun_inc = tick;
                state_d     = S_SEND;
                send_n_d    = 1'b0;
                to_cnt_d    = '0;
            end
            S_SEND: begin
                overrun_inc = tick;
                if (dac_isBusy) begin
                    state_d = S_WAIT;
                end else if (to_cnt == TO_MAX) begin
                    state_d     = S_IDLE;
                    overrun_inc = 1'b1;
                end else begin
                    send_n_d = 1'b0;
                    to_cnt_d = to_cnt + TO_W'(1);
                end
            end
            S_WAIT: begin
                overrun_inc = tick;
                if (dac_transmitComplete) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        overrun_d = overrunCount;
        if (overrun_inc && (overrunCount != 8'hFF)) begin
            overrun_d = overrunCount + 8'd1;
        end
    end

    // State and registered outputs
    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            state            <= S_IDLE;
            to_cnt           <= '0;
            dac_inputSample  <= SILENCE;
            dac_sendSample_n <= 1'b1;
            activeSource     <= SRC_NONE;
            keys_ack         <= 1'b0;
            song_ack         <= 1'b0;
            rec_ack          <= 1'b0;
            overrunCount     <= 8'd0;
        end else begin
            state            <= state_d;
            to_cnt           <= to_cnt_d;
            dac_inputSample  <= sample_d;
            dac_sendSample_n <= send_n_d;
            activeSource     <= src_d;
            keys_ack         <= keys_ack_d;
            song_ack         <= song_ack_d;
            rec_ack          <= rec_ack_d;
            overrunCount     <= overrun_d;
        end
    end

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Self-checking bench for dac_sample_scheduler: scoreboard of expected samples popped at each send.
module tb_dac_sample_scheduler;

    localparam int unsigned DIV  = 64;
    localparam int unsigned TOUT = 16;

    // acks = {keys, song, rec}
    typedef struct packed {
        logic [11:0] sample;
        logic [1:0]  src;
        logic [2:0]  acks;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  currentState;
    logic [11:0] keys_sample, song_sample, rec_sample;
    logic        keys_valid, song_valid, rec_valid;
    logic        keys_ack, song_ack, rec_ack;
    logic [11:0] dac_inputSample;
    logic        dac_sendSample_n;
    logic        dac_isBusy;
    logic        dac_transmitComplete;
    logic [7:0]  overrunCount;
    logic [1:0]  activeSource;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc;
    int n_sends  = 0;
    int n_rises  = 0;
    int fall_cyc = 0;
    int low_len  = 0;
    int keys_cnt = 0, song_cnt = 0, rec_cnt = 0;
    bit strict   = 1'b1;

    int busy_en        = 1;
    int busy_delay     = 3;
    int complete_delay = 20;

    exp_t sb[$];
    logic       prev_send_n = 1'b1;
    logic [2:0] prev_acks   = 3'b000;

    dac_sample_scheduler #(
        .SAMPLE_DIVIDER(DIV),
        .SEND_TIMEOUT  (TOUT),
        .SILENCE_CODE  (2048)
    ) dut (
        .clock_50Mhz         (clk),
        .reset_n             (reset_n),
        .currentState        (currentState),
        .keys_sample         (keys_sample),
        .keys_valid          (keys_valid),
        .keys_ack            (keys_ack),
        .song_sample         (song_sample),
        .song_valid          (song_valid),
        .song_ack            (song_ack),
        .rec_sample          (rec_sample),
        .rec_valid           (rec_valid),
        .rec_ack             (rec_ack),
        .dac_inputSample     (dac_inputSample),
        .dac_sendSample_n    (dac_sendSample_n),
        .dac_isBusy          (dac_isBusy),
        .dac_transmitComplete(dac_transmitComplete),
        .overrunCount        (overrunCount),
        .activeSource        (activeSource)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference selection, written from the source/state mapping
    function automatic exp_t model();
        exp_t e;
        int   m;
        e.sample = 12'h800;
        e.src    = 2'd0;
        e.acks   = 3'b000;
        case (currentState)
            5'd1, 5'd3: if (keys_valid) begin e.sample = keys_sample; e.src = 2'd1; e.acks = 3'b100; end
            5'd2:       if (song_valid) begin e.sample = song_sample; e.src = 2'd2; e.acks = 3'b010; end
            5'd4:       if (rec_valid)  begin e.sample = rec_sample;  e.src = 2'd3; e.acks = 3'b001; end
            default: ;
        endcase
`ifdef SAMPLE_MIX_EN
        if (currentState == 5'd3 && keys_valid && rec_valid) begin
            m = int'(keys_sample) + int'(rec_sample) - 2048;
            if (m < 0)    m = 0;
            if (m > 4095) m = 4095;
            e.sample = 12'(m);
            e.src    = 2'd1;
            e.acks   = 3'b101;
        end
`endif
        return e;
    endfunction

    task automatic apply(input logic [4:0] st,
                         input logic kv, input logic [11:0] ks,
                         input logic sv, input logic [11:0] ss,
                         input logic rv, input logic [11:0] rs);
        currentState = st;
        keys_valid = kv; keys_sample = ks;
        song_valid = sv; song_sample = ss;
        rec_valid  = rv; rec_sample  = rs;
        sb.push_back(model());
    endtask

    task automatic wait_send(input string tag, input int budget);
        int start;
        start = n_sends;
        repeat (budget) begin
            @(negedge clk); #1;
            if (n_sends != start) return;
        end
        check_val(tag, 32'(0), 32'(1));
    endtask

    task automatic wait_rise(input string tag, input int budget);
        int start;
        start = n_rises;
        repeat (budget) begin
            @(negedge clk); #1;
            if (n_rises != start) return;
        end
        check_val(tag, 32'(0), 32'(1));
    endtask

    // Output monitor: pops the scoreboard on every falling edge of send
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            prev_send_n = 1'b1;
            prev_acks   = 3'b000;
        end else begin
            if (prev_send_n && !dac_sendSample_n) begin
                fall_cyc = cyc;
                n_sends++;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check_val("sample", 32'(dac_inputSample), 32'(e.sample));
                    check_val("active_src", 32'(activeSource), 32'(e.src));
                    check_val("acks", 32'(prev_acks), 32'(e.acks));
                end else if (strict) begin
                    check_val("unexpected_send", 32'(0), 32'(1));
                end
            end
            if (!prev_send_n && dac_sendSample_n) begin
                low_len = cyc - fall_cyc;
                n_rises++;
            end
            if (keys_ack) keys_cnt++;
            if (song_ack) song_cnt++;
            if (rec_ack)  rec_cnt++;
            prev_send_n = dac_sendSample_n;
            prev_acks   = {keys_ack, song_ack, rec_ack};
        end
    end

    // SPI controller responder
    initial begin
        dac_isBusy = 1'b0;
        dac_transmitComplete = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_n && !dac_sendSample_n && busy_en != 0) begin
                repeat (busy_delay - 1) @(negedge clk);
                dac_isBusy = 1'b1;
                repeat (complete_delay) @(negedge clk);
                dac_isBusy = 1'b0;
                dac_transmitComplete = 1'b1;
                @(negedge clk);
                dac_transmitComplete = 1'b0;
            end
        end
    end

    initial begin
        int t0, t1, t2;
        reset_n = 1'b0;
        apply(5'd2, 1'b1, 12'h456, 1'b1, 12'h123, 1'b1, 12'h789);
        sb.push_back(model());
        sb.push_back(model());
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_send_n", 32'(dac_sendSample_n), 32'(1));
        check_val("rst_sample", 32'(dac_inputSample), 32'(12'h800));
        check_val("rst_acks", 32'({keys_ack, song_ack, rec_ack}), 32'(0));
        check_val("rst_overrun", 32'(overrunCount), 32'(0));
        check_val("rst_src", 32'(activeSource), 32'(0));
        reset_n = 1'b1;

        // Song source at the tick rate
        wait_send("send1_seen", 200); t0 = fall_cyc;
        check_val("first_send_latency", 32'(t0), 32'(DIV + 1));
        wait_send("send2_seen", 200); t1 = fall_cyc;
        wait_send("send3_seen", 200); t2 = fall_cyc;
        check_val("tick_period_a", 32'(t1 - t0), 32'(DIV));
        check_val("tick_period_b", 32'(t2 - t1), 32'(DIV));
        check_val("song_ack_count", 32'(song_cnt), 32'(3));
        check_val("keys_ack_count", 32'(keys_cnt), 32'(0));
        check_val("rec_ack_count", 32'(rec_cnt), 32'(0));
        check_val("overrun_steady", 32'(overrunCount), 32'(0));

        // Selection patterns, each changed while the previous transfer is in flight
        apply(5'd0, 1'b1, 12'h456, 1'b1, 12'h123, 1'b1, 12'h789); wait_send("silence_seen", 200);
        apply(5'd1, 1'b1, 12'h456, 1'b1, 12'h123, 1'b1, 12'h789); wait_send("keys_seen", 200);
        apply(5'd4, 1'b1, 12'h456, 1'b1, 12'h123, 1'b1, 12'h789); wait_send("rec_seen", 200);
        apply(5'd2, 1'b1, 12'h456, 1'b0, 12'h123, 1'b1, 12'h789); wait_send("song_invalid_seen", 200);
        apply(5'd4, 1'b1, 12'h456, 1'b1, 12'h123, 1'b0, 12'h789); wait_send("rec_invalid_seen", 200);
        apply(5'd3, 1'b1, 12'hC00, 1'b1, 12'h123, 1'b1, 12'hC00); wait_send("mix_hi_seen", 200);
        apply(5'd3, 1'b1, 12'h900, 1'b1, 12'h123, 1'b1, 12'h700); wait_send("mix_mid_seen", 200);
        apply(5'd7, 1'b1, 12'h456, 1'b1, 12'h123, 1'b1, 12'h789); wait_send("state7_seen", 200);
        check_val("overrun_after_patterns", 32'(overrunCount), 32'(0));

        // Send timeout then retry on the next tick
        repeat (40) @(negedge clk);
        busy_en = 0;
        apply(5'd2, 1'b1, 12'h456, 1'b1, 12'h123, 1'b1, 12'h789);
        wait_send("timeout_send_seen", 200); t0 = fall_cyc;
        wait_rise("timeout_release_seen", 40);
        check_val("timeout_low_len", 32'(low_len), 32'(TOUT));
        check_val("timeout_overrun", 32'(overrunCount), 32'(1));
        busy_en = 1;
        sb.push_back(model());
        wait_send("retry_seen", 200); t1 = fall_cyc;
        check_val("retry_period", 32'(t1 - t0), 32'(DIV));
        repeat (40) @(negedge clk);
        check_val("retry_overrun", 32'(overrunCount), 32'(1));

        // Dropped tick while waiting for a slow completion
        complete_delay = 100;
        sb.push_back(model());
        wait_send("slow_send_seen", 200); t0 = fall_cyc;
        repeat (10) @(negedge clk);
        complete_delay = 20;
        sb.push_back(model());
        wait_send("after_drop_seen", 300); t1 = fall_cyc;
        check_val("drop_period", 32'(t1 - t0), 32'(2 * DIV));
        check_val("drop_overrun", 32'(overrunCount), 32'(2));
        repeat (40) @(negedge clk);

        // Saturation: every tick times out
        busy_en = 0;
        strict  = 1'b0;
        repeat (256 * DIV) @(negedge clk);
        check_val("overrun_saturated", 32'(overrunCount), 32'(255));

        // Reset in the middle of SEND
        wait_send("pre_reset_send_seen", 200);
        repeat (3) @(negedge clk);
        #1;
        check_val("pre_reset_send_low", 32'(dac_sendSample_n), 32'(0));
        reset_n = 1'b0;
        #1;
        check_val("async_rst_send_n", 32'(dac_sendSample_n), 32'(1));
        check_val("async_rst_sample", 32'(dac_inputSample), 32'(12'h800));
        check_val("async_rst_overrun", 32'(overrunCount), 32'(0));
        check_val("async_rst_src", 32'(activeSource), 32'(0));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
